instr_fetch_stage: RTL and testbench
====================================

// Module: instr_fetch_stage
//
// PURPOSE
// - Fetch stage plus IF/ID pipeline register of the MIPS-style datapath.
// - Keeps the PC and fetches words from instruction memory over a req/ack handshake.
// - Holds the fetched word for decode and pre-decodes id_imm/id_zero_ext.
// - id_imm and id_zero_ext drive the sign extender directly.
// - Supports stall (one-entry skid buffer) and redirect (branch/jump).
//
// PARAMETERS
// - RESET_PC  32'h0000_0000  PC value loaded on reset; must be word aligned.
//
// PORTS
// - clk          in   1   rising-edge clock
// - rst_n        in   1   asynchronous reset, active low
// - imem_req     out  1   fetch request to instruction memory
// - imem_addr    out  32  fetch address (= PC; bits [1:0] always 0)
// - imem_ack     in   1   word returned this cycle; only sampled while imem_req=1
// - imem_rdata   in   32  instruction word, valid when imem_ack=1
// - stall        in   1   ID cannot accept a new word; hold id_* outputs
// - redirect     in   1   load PC from redirect_pc; has priority over stall
// - redirect_pc  in   32  target address; bits [1:0] ignored (forced 0)
// - id_valid     out  1   id_* outputs hold a real instruction
// - id_pc        out  32  PC of the instruction in ID
// - id_instr     out  32  instruction in ID (32'h0 when invalid)
// - id_imm       out  16  id_instr[15:0]
// - id_zero_ext  out  1   1 when opcode is ANDI/ORI/XORI/LUI (6'h0C..6'h0F), else 0
//
// BEHAVIOUR
// Reset (async, rst_n=0):
// - PC=RESET_PC, state=S_IDLE, skid buffer empty.
// - imem_req=0, id_valid=0, id_pc=0, id_instr=0, id_imm=0, id_zero_ext=0.
// FSM states:
// - S_IDLE: imem_req=0. Goes to S_FETCH on the first edge after reset is released.
// - S_FETCH: imem_req=1, imem_addr=PC; the request is held until ack.
//   - Ack & !stall: IF/ID <= {PC, rdata}, id_valid=1 next cycle, PC+=4, stay in S_FETCH.
//   - Ack & stall: word goes to the skid buffer, PC+=4, go to S_HOLD.
// - S_HOLD: imem_req=0; id_* and the skid buffer are held.
//   - When stall=0: IF/ID <= skid buffer, buffer empties, return to S_FETCH.
// No-ack while !stall:
// - id_valid=0 next cycle (bubble). id_instr is forced to 0 so decode sees a NOP.
// Stall:
// - With no ack, all id_* outputs are held unchanged.
// - At most one word is buffered; no request is issued while the buffer is full.
// Redirect (any state):
// - PC <= redirect_pc & ~3, skid buffer cleared, id_valid <= 0, next state S_FETCH.
// - Redirect together with stall: redirect wins and the flush happens.
// - Redirect together with ack: see CONFIGURATION.
// Timing and arithmetic:
// - Latency: ack cycle -> id_valid/id_instr on the next edge.
// - Throughput: 1 instruction per cycle with a single-cycle ack.
// - PC+4 is computed modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
// - id_imm and id_zero_ext are registered together with id_instr (no combinational path from imem_rdata).
// - Reset asserted mid-fetch: all state is cleared at once; any ack that follows is ignored.
//
// CONFIGURATION
// - Macro DELAY_SLOT_EN defined (branch delay slot):
//   - An ack arriving in the redirect cycle is delivered to ID (id_valid=1, id_pc = old PC).
//   - That word is the delay slot. PC still loads redirect_pc.
// - Macro DELAY_SLOT_EN undefined:
//   - An ack in the redirect cycle is dropped and id_valid=0 next cycle.
//
// TESTING
// - Reset, single-cycle ack with rdata=32'h3402_00FF (ORI):
//   - -> imem_addr 0,4,8...; id_valid=1 one cycle after the ack.
//   - -> id_imm=16'h00FF, id_zero_ext=1.
// - Ack rdata=32'h2002_FFFF (ADDI) -> id_imm=16'hFFFF, id_zero_ext=0.
//   - Ack stays low for 3 cycles -> id_valid=0 and id_instr=0 for those cycles.
// - Stall held 4 cycles while an ack lands:
//   - -> id_* frozen, exactly one extra word buffered, imem_req=0 in S_HOLD.
//   - -> on release the buffered word appears next cycle; no word lost or duplicated.
// - redirect=1, redirect_pc=32'h0000_1003 with ack in the same cycle:
//   - -> next imem_addr=32'h0000_1000.
//   - -> id_valid=0 (macro off) or id_valid=1 with id_pc = old PC (DELAY_SLOT_EN).
// - Redirect to 32'hFFFF_FFFC, then two acks -> imem_addr sequence FFFF_FFFC, 0000_0000.
// - rst_n pulsed low mid-fetch -> outputs 0 immediately; next fetch from RESET_PC after S_IDLE.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC, imem req/ack handshake, IF/ID register with imm/zero-ext pre-decode.
// Latency: a word acked in cycle N appears on id_* after the next rising edge.
// Backpressure: stall freezes id_*; one acked word parks in a skid buffer and fetching pauses until it drains.
// Optional feature macro: DELAY_SLOT_EN (word acked in a redirect cycle is kept as the delay slot).
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [15:0] id_imm,
  output logic        id_zero_ext
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic        r_skid_vld;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_instr;

  logic        r_id_valid;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_instr;
  logic [15:0] r_id_imm;
  logic        r_id_zext;

  logic        w_ack;
  logic        w_load_id;
  logic        w_load_skid;
  logic        w_drain_skid;
  logic        w_clear_id;
  logic        w_pc_inc;
  logic [31:0] w_target;
  logic        w_rdata_zext;
  logic        w_skid_zext;

  // Ack only counts while a request is actually outstanding.
  assign w_ack        = imem_ack & (r_state == S_FETCH);
  assign w_target     = redirect_pc & ~32'h3;
  // ANDI/ORI/XORI/LUI are opcodes 6'b0011xx, so the top nibble identifies them.
  assign w_rdata_zext = (imem_rdata[31:28] == 4'b0011);
  assign w_skid_zext  = (r_skid_instr[31:28] == 4'b0011);

  assign imem_addr    = r_pc;
  assign id_valid     = r_id_valid;
  assign id_pc        = r_id_pc;
  assign id_instr     = r_id_instr;
  assign id_imm       = r_id_imm;
  assign id_zero_ext  = r_id_zext;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; a redirect always restarts fetching.
  always_comb begin
    w_state_nxt = r_state;
    if (redirect) begin
      w_state_nxt = S_FETCH;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_FETCH;
        S_FETCH: if (w_ack && stall) w_state_nxt = S_HOLD;
        S_HOLD:  if (!stall) w_state_nxt = S_FETCH;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output logic: memory request plus datapath load strobes for this cycle.
  always_comb begin
    imem_req     = (r_state == S_FETCH);
    w_load_id    = 1'b0;
    w_load_skid  = 1'b0;
    w_drain_skid = 1'b0;
    w_clear_id   = 1'b0;
    w_pc_inc     = 1'b0;
    if (redirect) begin
`ifdef DELAY_SLOT_EN
      // The word fetched alongside the branch is its delay slot.
      w_load_id  = w_ack;
      w_clear_id = !w_ack;
`else
      w_clear_id = 1'b1;
`endif
    end else begin
      case (r_state)
        S_FETCH: begin
          w_pc_inc    = w_ack;
          w_load_skid = w_ack & stall;
          w_load_id   = w_ack & !stall;
          w_clear_id  = !w_ack & !stall;
        end
        S_HOLD:  w_drain_skid = r_skid_vld & !stall;
        default: ;
      endcase
    end
  end

  // Program counter: redirect target, or advance by one word per accepted ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect) begin
      r_pc <= w_target;
    end else if (w_pc_inc) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  // Skid buffer: catches the single word acked while decode is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_vld   <= 1'b0;
      r_skid_pc    <= 32'h0;
      r_skid_instr <= 32'h0;
    end else if (redirect) begin
      r_skid_vld   <= 1'b0;
    end else if (w_load_skid) begin
      r_skid_vld   <= 1'b1;
      r_skid_pc    <= r_pc;
      r_skid_instr <= imem_rdata;
    end else if (w_drain_skid) begin
      r_skid_vld   <= 1'b0;
    end
  end

  // IF/ID register; invalid slots carry an all-zero word so decode sees a NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_valid <= 1'b0;
      r_id_pc    <= 32'h0;
      r_id_instr <= 32'h0;
      r_id_imm   <= 16'h0;
      r_id_zext  <= 1'b0;
    end else if (w_load_id) begin
      r_id_valid <= 1'b1;
      r_id_pc    <= r_pc;
      r_id_instr <= imem_rdata;
      r_id_imm   <= imem_rdata[15:0];
      r_id_zext  <= w_rdata_zext;
    end else if (w_drain_skid) begin
      r_id_valid <= 1'b1;
      r_id_pc    <= r_skid_pc;
      r_id_instr <= r_skid_instr;
      r_id_imm   <= r_skid_instr[15:0];
      r_id_zext  <= w_skid_zext;
    end else if (w_clear_id) begin
      r_id_valid <= 1'b0;
      r_id_instr <= 32'h0;
      r_id_imm   <= 16'h0;
      r_id_zext  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
`timescale 1ns/1ps
module tb_instr_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [15:0] id_imm;
  logic        id_zero_ext;

  int checks = 0;
  int errors = 0;

  // Reference model: program counter, what decode holds, and a queue of parked words.
  logic [31:0] m_pc;
  bit          m_started;
  bit          m_v;
  logic [31:0] m_ipc;
  logic [31:0] m_instr;
  logic [63:0] m_buf[$];

  instr_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .id_imm(id_imm), .id_zero_ext(id_zero_ext)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = RST_PC;
    m_started = 1'b0;
    m_v       = 1'b0;
    m_ipc     = 32'h0;
    m_instr   = 32'h0;
    m_buf.delete();
  endtask

  // One clock of the fetch rules, from the inputs presented during that cycle.
  task automatic model_step(input bit a, input bit s, input bit r,
                            input logic [31:0] rpc, input logic [31:0] rd);
    bit req;
    bit acked;
    req   = m_started && (m_buf.size() == 0);
    acked = req && a;
    if (r) begin
      if (DS && acked) begin
        m_v = 1'b1; m_ipc = m_pc; m_instr = rd;
      end else begin
        m_v = 1'b0; m_instr = 32'h0;
      end
      m_pc = rpc & ~32'h3;
      m_buf.delete();
    end else if (acked) begin
      if (s) m_buf.push_back({m_pc, rd});
      else begin
        m_v = 1'b1; m_ipc = m_pc; m_instr = rd;
      end
      m_pc = m_pc + 32'd4;
    end else if (!s) begin
      if (m_buf.size() > 0) begin
        {m_ipc, m_instr} = m_buf.pop_front();
        m_v = 1'b1;
      end else begin
        m_v = 1'b0; m_instr = 32'h0;
      end
    end
    m_started = 1'b1;
  endtask

  task automatic check_all();
    int unsigned op;
    bit zext;
    op   = m_instr >> 26;
    zext = (op >= 12) && (op <= 15);
    chk("imem_req", {31'h0, imem_req}, {31'h0, (m_started && m_buf.size() == 0)});
    chk("imem_addr", imem_addr, m_pc);
    chk("id_valid", {31'h0, id_valid}, {31'h0, m_v});
    chk("id_instr", id_instr, m_instr);
    chk("id_imm", {16'h0, id_imm}, m_instr & 32'h0000_FFFF);
    chk("id_zero_ext", {31'h0, id_zero_ext}, {31'h0, zext});
    if (m_v) chk("id_pc", id_pc, m_ipc);
  endtask

  // Present inputs at the falling edge, clock once, then compare at the next falling edge.
  task automatic step(input bit a, input bit s, input bit r,
                      input logic [31:0] rpc, input logic [31:0] rd);
    imem_ack = a; stall = s; redirect = r; redirect_pc = rpc; imem_rdata = rd;
    @(posedge clk);
    model_step(a, s, r, rpc, rd);
    @(negedge clk);
    check_all();
  endtask

  logic [31:0] w0, w1, w2;

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    model_reset();
    @(negedge clk);
    check_all();
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    rst_n = 1'b1;

    // Leave idle, then ORI and ADDI pre-decode.
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("first_addr", imem_addr, RST_PC);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h3402_00FF);
    chk("ori_imm", {16'h0, id_imm}, 32'h0000_00FF);
    chk("ori_zext", {31'h0, id_zero_ext}, 32'h1);
    chk("ori_addr_next", imem_addr, 32'h4);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h2002_FFFF);
    chk("addi_imm", {16'h0, id_imm}, 32'h0000_FFFF);
    chk("addi_zext", {31'h0, id_zero_ext}, 32'h0);

    // Three cycles without ack produce bubbles.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, $urandom);
      chk("bubble_valid", {31'h0, id_valid}, 32'h0);
      chk("bubble_instr", id_instr, 32'h0);
    end

    // Stall for four cycles while one ack lands.
    w0 = 32'h1111_0001; w1 = 32'h3C01_2222; w2 = 32'h2403_3333;
    step(1'b1, 1'b0, 1'b0, 32'h0, w0);
    step(1'b1, 1'b1, 1'b0, 32'h0, w1);
    chk("hold_req", {31'h0, imem_req}, 32'h0);
    chk("hold_frozen", id_instr, w0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, $urandom);
      chk("hold_frozen_more", id_instr, w0);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("skid_release", id_instr, w1);
    step(1'b1, 1'b0, 1'b0, 32'h0, w2);
    chk("after_skid", id_instr, w2);

    // Redirect with an ack in the same cycle.
    step(1'b1, 1'b0, 1'b1, 32'h0000_1003, 32'hABCD_0000);
    chk("redir_addr", imem_addr, 32'h0000_1000);
    chk("redir_valid", {31'h0, id_valid}, {31'h0, DS});

    // Wrap-around of the PC.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 32'h0, $urandom);
    chk("wrap_addr1", imem_addr, 32'h0000_0000);
    step(1'b1, 1'b0, 1'b0, 32'h0, $urandom);
    chk("wrap_id_pc", id_pc, 32'h0000_0000);

    // Reset pulsed mid-fetch with an ack pending.
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF);
    chk("post_rst_addr", imem_addr, RST_PC);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h3003_0001);
    chk("post_rst_id_pc", id_pc, RST_PC);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 5, $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
